// File: rtl/alu_pkg.sv
// Shared definitions for the structural ALU blocks: datapath width,
// multiplier iteration count and the multiplier FSM state encoding.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int MUL_ITER  = 32;
    localparam int MUL_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // True on the cycle that processes the final iteration.
    function automatic logic mul_last_iter(input logic [MUL_CNT_W-1:0] count);
        return count == MUL_CNT_W'(MUL_ITER - 1);
    endfunction

endpackage

// File: rtl/add_32.sv
// Existing 32-bit combinational adder: unsigned carry out plus signed
// overflow flag for two's-complement users.
module add_32 (
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic [31:0] sum,
    output logic        carry_out,
    output logic        overflow
);

    assign {carry_out, sum} = {1'b0, operand_a} + {1'b0, operand_b};

    // Signed overflow: like-signed operands producing an opposite-signed sum.
    assign overflow = (operand_a[31] == operand_b[31]) && (sum[31] != operand_a[31]);

endmodule

// File: rtl/mult_seq_32.sv
// Sequential unsigned 32x32->64 shift-and-add multiplier built around add_32.
// One iteration per cycle, fixed 32 iterations, valid/ready on both sides.
module mult_seq_32
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 hi_nonzero,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    // Handshake rule: a transfer happens on a rising edge where valid and
    // ready are both high; ready/valid here depend only on registered state.

    mul_state_t             state_q, state_d;
    logic [WIDTH-1:0]       mcand_q, mcand_d;
    logic [WIDTH-1:0]       acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]       acc_lo_q, acc_lo_d;
    logic [MUL_CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0]     product_q, product_d;
    logic                   hi_nonzero_q, hi_nonzero_d;

    logic [WIDTH-1:0]       add_b;
    logic [WIDTH-1:0]       add_sum;
    logic                   add_carry;
    logic                   unused_ovf;

    // Multiplicand is added only when the current multiplier bit is set.
    assign add_b = acc_lo_q[0] ? mcand_q : '0;

    add_32 u_add_32 (
        .operand_a (acc_hi_q),
        .operand_b (add_b),
        .sum       (add_sum),
        .carry_out (add_carry),
        .overflow  (unused_ovf)
    );

    always_comb begin
        state_d      = state_q;
        mcand_d      = mcand_q;
        acc_hi_d     = acc_hi_q;
        acc_lo_d     = acc_lo_q;
        count_d      = count_q;
        product_d    = product_q;
        hi_nonzero_d = hi_nonzero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = multiplicand;
                    acc_lo_d = multiplier;
                    acc_hi_d = '0;
                    count_d  = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                // Carry becomes the new top bit; sum LSB shifts into the low half.
                acc_hi_d = {add_carry, add_sum[WIDTH-1:1]};
                acc_lo_d = {add_sum[0], acc_lo_q[WIDTH-1:1]};
                count_d  = count_q + MUL_CNT_W'(1);
                if (mul_last_iter(count_q)) begin
                    state_d      = DONE;
                    product_d    = {acc_hi_d, acc_lo_d};
                    hi_nonzero_d = (acc_hi_d != '0);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mcand_q      <= '0;
            acc_hi_q     <= '0;
            acc_lo_q     <= '0;
            count_q      <= '0;
            product_q    <= '0;
            hi_nonzero_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mcand_q      <= mcand_d;
            acc_hi_q     <= acc_hi_d;
            acc_lo_q     <= acc_lo_d;
            count_q      <= count_d;
            product_q    <= product_d;
            hi_nonzero_q <= hi_nonzero_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q == BUSY);
    assign out_valid  = (state_q == DONE);
    assign product    = product_q;
    assign hi_nonzero = hi_nonzero_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mult_seq_32.sv
// Directed and randomised checks of mult_seq_32 against a 64-bit arithmetic
// reference product, including latency, backpressure and mid-operation reset.
module tb_mult_seq_32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] product;
    logic        hi_nonzero;
    logic        busy;
    logic [1:0]  dbg_state;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];

    mult_seq_32 dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .hi_nonzero   (hi_nonzero),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},   64'(in_ready),   64'd1);
        check({tag, "_out_valid"},  64'(out_valid),  64'd0);
        check({tag, "_busy"},       64'(busy),       64'd0);
        check({tag, "_product"},    product,         64'd0);
        check({tag, "_hi_nonzero"}, 64'(hi_nonzero), 64'd0);
    endtask

    // One complete operation: accept, wait for result, optional backpressure
    // gap (optionally poking in_valid during it), then output handshake.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int gap, input logic poke, input logic chk_lat);
        logic [63:0] exp;
        int          lat;
        lat = 0;
        while (!in_ready && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        in_valid     = 1'b1;
        multiplicand = a;
        multiplier   = b;
        exp_q.push_back({32'b0, a} * {32'b0, b});
        @(negedge clk);
        in_valid     = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        if (chk_lat) begin
            check("busy_after_accept", 64'(busy), 64'd1);
            check("in_ready_in_busy",  64'(in_ready), 64'd0);
        end
        lat = 0;
        while (!out_valid && lat < 100) begin
            out_ready    = 1'($urandom_range(0, 1));
            in_valid     = 1'($urandom_range(0, 1));
            multiplicand = $urandom;
            multiplier   = $urandom;
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        if (chk_lat || lat >= 100) check("latency", 64'(lat), 64'd32);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
        out_ready = 1'b0;
        for (int i = 0; i < gap; i++) begin
            if (poke) begin
                in_valid     = 1'b1;
                multiplicand = $urandom;
                multiplier   = $urandom;
                check("bp_out_valid", 64'(out_valid), 64'd1);
                check("bp_in_ready",  64'(in_ready),  64'd0);
            end
            check("bp_product", product, exp);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("product",    product,          exp);
        check("hi_nonzero", 64'(hi_nonzero),  64'(exp[63:32] != 32'd0));
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_hs", 64'(out_valid), 64'd0);
        check("in_ready_after_hs",  64'(in_ready),  64'd1);
    endtask

    initial begin
        // Reset from power-up
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Basic product, carry path, output backpressure
        run_op(32'h0000_0007, 32'h0000_0006, 0, 1'b0, 1'b1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b1);
        run_op(32'h0001_0000, 32'h0001_0000, 10, 1'b1, 1'b1);

        // Mid-operation reset with operand/in_valid churn during BUSY
        in_valid     = 1'b1;
        multiplicand = 32'd5;
        multiplier   = 32'd3;
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            in_valid     = 1'($urandom_range(0, 1));
            multiplicand = $urandom;
            multiplier   = $urandom;
            check("midop_no_out_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midop_reset");
        run_op(32'd5, 32'd3, 0, 1'b0, 1'b1);

        // Randomised regression
        for (int n = 0; n < 1000; n++) begin
            logic [31:0] a, b;
            case ($urandom_range(0, 7))
                0:       a = '0;
                1:       a = '1;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = '1;
                default: b = $urandom;
            endcase
            run_op(a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'(n < 20));
        end

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
